// File: rtl/param_fetch_stream.sv
// rtl/param_fetch_stream.sv - sparse-layer parameter fetcher streaming (value, weight) pairs
module param_fetch_stream #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_adds,
  input  logic [ADDR_W-1:0] param_base,
  input  logic [ADDR_W-1:0] input_base,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [DATA_W-1:0] weight_val,
  output logic [ADDR_W-1:0] index_addr,
  input  logic [DATA_W-1:0] index_val,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] input_val,
  output logic [DATA_W-1:0] out_val,
  output logic [DATA_W-1:0] out_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  emit_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] W_ADDR = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] I_ADDR = 3'd3;
  localparam logic [2:0] I_DATA = 3'd4;
  localparam logic [2:0] EMIT   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]        state;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  numLat;
  logic [ADDR_W-1:0] inBaseLat;
  logic [DATA_W-1:0] weightLat;
  logic [ADDR_W-1:0] idxExt;
  logic              skipEntry;
  logic              isLast;
  logic              doAdvance;

  // The index word becomes an address offset: truncate or zero-extend to the address width.
  generate
    if (DATA_W >= ADDR_W) begin : gIdxTrunc
      assign idxExt = index_val[ADDR_W-1:0];
    end else begin : gIdxPad
      assign idxExt = {{(ADDR_W-DATA_W){1'b0}}, index_val};
    end
  endgenerate

  assign busy = (state != IDLE);

  // Decide when the walk moves to the next entry: a skipped zero weight or an accepted pair.
  always_comb begin
    skipEntry = SKIP_ZERO && (weight_val == '0);
    isLast    = (idx == numLat - CNT_W'(1));
    doAdvance = ((state == W_DATA) && skipEntry) || ((state == EMIT) && out_ready);
  end

  // Main sequencer: address walk, gather, output hold and run bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      numLat      <= '0;
      inBaseLat   <= '0;
      weightLat   <= '0;
      weight_addr <= '0;
      index_addr  <= '0;
      input_addr  <= '0;
      out_val     <= '0;
      out_weight  <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      emit_count  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Cancel wins over everything; addresses and count keep their last values.
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              numLat      <= num_adds;
              inBaseLat   <= input_base;
              idx         <= '0;
              emit_count  <= '0;
              weight_addr <= param_base;
              index_addr  <= param_base;
              state       <= (num_adds == '0) ? DONE : W_ADDR;
            end
          end
          W_ADDR: state <= W_DATA;
          W_DATA: begin
            weightLat <= weight_val;
            if (!skipEntry) begin
              input_addr <= inBaseLat + idxExt;
              state      <= I_ADDR;
            end
          end
          I_ADDR: state <= I_DATA;
          I_DATA: begin
            out_val    <= input_val;
            out_weight <= weightLat;
            out_valid  <= 1'b1;
            state      <= EMIT;
          end
          EMIT: begin
            if (out_ready) begin
              out_valid  <= 1'b0;
              emit_count <= emit_count + CNT_W'(1);
            end
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase

        if (doAdvance) begin
          if (isLast) begin
            state <= DONE;
          end else begin
            idx         <= idx + CNT_W'(1);
            weight_addr <= weight_addr + ADDR_W'(1);
            index_addr  <= index_addr + ADDR_W'(1);
            state       <= W_ADDR;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_fetch_stream.sv
// tb/tb_param_fetch_stream.sv - self-checking bench for param_fetch_stream
module tb_param_fetch_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] num_adds = '0;
  logic [15:0] param_base = '0;
  logic [15:0] input_base = '0;

  logic [15:0] wMem  [0:65535];
  logic [15:0] xMem  [0:65535];
  logic [15:0] inMem [0:65535];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int startCyc = 0;
  logic [31:0] gotQ[$];

  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gDut
    logic [15:0] wa, ia, xa, ov, ow, ec, wv, iv, xv;
    logic        vld, dn, bz;
    logic [31:0] expQ[$];
    int          accCnt = 0, doneCnt = 0, validCnt = 0, firstValid = -1, doneCyc = -1, expCnt = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevPair = '0;
    logic        saw104 = 1'b0;

    param_fetch_stream #(.DATA_W(16), .ADDR_W(16), .CNT_W(16), .SKIP_ZERO(g == 1)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .num_adds(num_adds), .param_base(param_base), .input_base(input_base),
      .weight_addr(wa), .weight_val(wv), .index_addr(ia), .index_val(iv),
      .input_addr(xa), .input_val(xv),
      .out_val(ov), .out_weight(ow), .out_valid(vld), .out_ready(out_ready),
      .done(dn), .busy(bz), .emit_count(ec)
    );

    // Synchronous-read RAM models, one cycle from address to data.
    always @(posedge clk) begin
      wv <= wMem[wa];
      iv <= xMem[ia];
      xv <= inMem[xa];
    end

    // Compare process: pairs against the model queue, hold rule, address tie.
    always @(negedge clk) begin
      if (rst) begin
        check($sformatf("addr_tie%0d", g), {48'd0, ia}, {48'd0, wa});
        if (prevStall)
          check($sformatf("hold%0d", g), {31'd0, vld, ov, ow}, {31'd0, 1'b1, prevPair});
        if (vld && out_ready && !abort) begin
          accCnt++;
          if (g == 0) gotQ.push_back({ov, ow});
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_pair%0d got=%h want=none", g, {ov, ow});
          end else begin
            check($sformatf("pair%0d", g), {32'd0, ov, ow}, {32'd0, expQ.pop_front()});
          end
        end
        prevStall = vld && !out_ready && !abort;
        prevPair  = {ov, ow};
        if (dn) begin
          doneCnt++;
          doneCyc = cyc;
        end
        if (vld) begin
          validCnt++;
          if (firstValid < 0) firstValid = cyc;
        end
        if (xa == 16'h0104) saw104 = 1'b1;
      end
    end
  end

  task automatic resetTrack();
    gotQ.delete();
    gDut[0].expQ.delete(); gDut[1].expQ.delete();
    gDut[0].accCnt = 0;   gDut[1].accCnt = 0;
    gDut[0].doneCnt = 0;  gDut[1].doneCnt = 0;
    gDut[0].validCnt = 0; gDut[1].validCnt = 0;
    gDut[0].firstValid = -1; gDut[1].firstValid = -1;
    gDut[0].doneCyc = -1; gDut[1].doneCyc = -1;
    gDut[0].prevStall = 1'b0; gDut[1].prevStall = 1'b0;
    gDut[0].saw104 = 1'b0; gDut[1].saw104 = 1'b0;
    gDut[0].expCnt = 0; gDut[1].expCnt = 0;
  endtask

  // Reference: list of pairs a run must emit, straight from the memory contents.
  task automatic modelRun(input logic [15:0] num, input logic [15:0] pb, input logic [15:0] ib);
    for (int k = 0; k < int'(num); k++) begin
      logic [15:0] a, w, x, ia;
      a  = pb + 16'(k);
      w  = wMem[a];
      x  = xMem[a];
      ia = ib + x;
      gDut[0].expQ.push_back({inMem[ia], w});
      gDut[0].expCnt++;
      if (w != 16'd0) begin
        gDut[1].expQ.push_back({inMem[ia], w});
        gDut[1].expCnt++;
      end
    end
  endtask

  task automatic startRun(input logic [15:0] num, input logic [15:0] pb, input logic [15:0] ib);
    resetTrack();
    modelRun(num, pb, ib);
    @(posedge clk); #1;
    num_adds = num; param_base = pb; input_base = ib; start = 1'b1;
    startCyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((gDut[0].bz || gDut[1].bz) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL timeout_%s got=busy want=idle", tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic finishRun(input string tag);
    check({tag, "_left0"}, 64'(gDut[0].expQ.size()), 64'd0);
    check({tag, "_left1"}, 64'(gDut[1].expQ.size()), 64'd0);
    check({tag, "_cnt0"}, {48'd0, gDut[0].ec}, 64'(gDut[0].expCnt));
    check({tag, "_cnt1"}, {48'd0, gDut[1].ec}, 64'(gDut[1].expCnt));
    check({tag, "_done0"}, 64'(gDut[0].doneCnt), 64'd1);
    check({tag, "_done1"}, 64'(gDut[1].doneCnt), 64'd1);
  endtask

  task automatic waitCond0Ec(input logic [15:0] v, input string tag);
    int n;
    n = 0;
    while (gDut[0].ec != v && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL timeout_%s got=%0d want=%0d", tag, gDut[0].ec, v);
    end
  endtask

  task automatic waitValid0(input string tag);
    int n;
    n = 0;
    while (!gDut[0].vld && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL timeout_%s got=0 want=valid", tag);
    end
  endtask

  task automatic zeroCheck(input string tag);
    check({tag, "_addr0"}, {16'd0, gDut[0].wa, gDut[0].ia, gDut[0].xa}, 64'd0);
    check({tag, "_data0"}, {16'd0, gDut[0].ov, gDut[0].ow, gDut[0].ec}, 64'd0);
    check({tag, "_flag0"}, {61'd0, gDut[0].vld, gDut[0].dn, gDut[0].bz}, 64'd0);
    check({tag, "_addr1"}, {16'd0, gDut[1].wa, gDut[1].ia, gDut[1].xa}, 64'd0);
    check({tag, "_data1"}, {16'd0, gDut[1].ov, gDut[1].ow, gDut[1].ec}, 64'd0);
    check({tag, "_flag1"}, {61'd0, gDut[1].vld, gDut[1].dn, gDut[1].bz}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      wMem[a]  = 16'd0;
      xMem[a]  = 16'd0;
      inMem[a] = 16'(a * 3 + 1);
    end
    wMem[16'h10] = 16'd5; wMem[16'h11] = 16'd9; wMem[16'h12] = 16'd7;
    xMem[16'h10] = 16'd2; xMem[16'h11] = 16'd4; xMem[16'h12] = 16'd1;
    wMem[16'h20] = 16'd5; wMem[16'h21] = 16'd0; wMem[16'h22] = 16'd7;
    xMem[16'h20] = 16'd2; xMem[16'h21] = 16'd4; xMem[16'h22] = 16'd1;
    wMem[16'h30] = 16'd1; xMem[16'h30] = 16'd3;

    // 1: asynchronous reset mid-clock, then idle
    #3 rst = 1'b0;
    #1 zeroCheck("rst_init");
    @(posedge clk); #1 rst = 1'b1;
    resetTrack();
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {62'd0, gDut[0].bz, gDut[1].bz}, 64'd0);
    check("idle_nodone", 64'(gDut[0].doneCnt + gDut[1].doneCnt), 64'd0);

    // 2: basic three-entry run, consumer always ready
    out_ready = 1'b1;
    startRun(16'd3, 16'h0010, 16'h0100);
    waitIdle("t2");
    finishRun("t2");
    check("t2_latency", 64'(gDut[0].firstValid - startCyc), 64'd5);
    check("t2_n", 64'(gotQ.size()), 64'd3);
    if (gotQ.size() == 3) begin
      check("t2_p0", {32'd0, gotQ[0]}, {32'd0, 16'h0307, 16'd5});
      check("t2_p1", {32'd0, gotQ[1]}, {32'd0, 16'h030D, 16'd9});
      check("t2_p2", {32'd0, gotQ[2]}, {32'd0, 16'h0304, 16'd7});
    end
    check("t2_ec", {48'd0, gDut[0].ec}, 64'd3);

    // 3: stall on pair 2, plus a start while busy that must be ignored
    startRun(16'd3, 16'h0010, 16'h0100);
    waitCond0Ec(16'd1, "t3_ec1");
    out_ready = 1'b0;
    waitValid0("t3_v2");
    repeat (2) @(posedge clk);
    #1;
    num_adds = 16'd7; param_base = 16'h0030; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    waitIdle("t3");
    finishRun("t3");
    check("t3_n", 64'(gotQ.size()), 64'd3);
    if (gotQ.size() == 3) check("t3_p1", {32'd0, gotQ[1]}, {32'd0, 16'h030D, 16'd9});

    // 4: zero weight in the middle, skip and no-skip variants side by side
    startRun(16'd3, 16'h0020, 16'h0100);
    waitIdle("t4");
    finishRun("t4");
    check("t4_ec_noskip", {48'd0, gDut[0].ec}, 64'd3);
    check("t4_ec_skip", {48'd0, gDut[1].ec}, 64'd2);
    check("t4_addr_noskip", {63'd0, gDut[0].saw104}, 64'd1);
    check("t4_addr_skip", {63'd0, gDut[1].saw104}, 64'd0);

    // 5: empty run, then input address wrap
    startRun(16'd0, 16'h0010, 16'h0100);
    waitIdle("t5a");
    finishRun("t5a");
    check("t5_done_lat", 64'(gDut[0].doneCyc - startCyc), 64'd2);
    check("t5_novalid", 64'(gDut[0].validCnt + gDut[1].validCnt), 64'd0);
    startRun(16'd1, 16'h0030, 16'hFFFE);
    waitIdle("t5b");
    finishRun("t5b");
    check("t5_wrap_addr", {48'd0, gDut[0].xa}, 64'h0001);
    if (gotQ.size() == 1) check("t5_wrap_pair", {32'd0, gotQ[0]}, {32'd0, 16'd4, 16'd1});
    else check("t5_wrap_n", 64'(gotQ.size()), 64'd1);

    // 6: abort while a pair is offered with out_ready high, start in the same cycle
    startRun(16'd3, 16'h0010, 16'h0100);
    waitCond0Ec(16'd1, "t6_ec1");
    out_ready = 1'b0;
    waitValid0("t6_v2");
    abort = 1'b1; start = 1'b1; out_ready = 1'b1;
    num_adds = 16'd1; param_base = 16'h0030;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("t6_busy", {62'd0, gDut[0].bz, gDut[1].bz}, 64'd0);
    check("t6_valid", {62'd0, gDut[0].vld, gDut[1].vld}, 64'd0);
    check("t6_ec_hold", {48'd0, gDut[0].ec}, 64'd1);
    check("t6_addr_hold", {48'd0, gDut[0].wa}, 64'h0011);
    repeat (3) @(posedge clk);
    #1;
    check("t6_nodone", 64'(gDut[0].doneCnt + gDut[1].doneCnt), 64'd0);
    check("t6_acc", 64'(gDut[0].accCnt), 64'd1);
    check("t6_still_idle", {62'd0, gDut[0].bz, gDut[1].bz}, 64'd0);

    // 1b: asynchronous reset in the middle of a run discards it
    startRun(16'd3, 16'h0010, 16'h0100);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 zeroCheck("rst_mid");
    @(posedge clk); #1 rst = 1'b1;
    resetTrack();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_idle", {62'd0, gDut[0].bz, gDut[1].bz}, 64'd0);
    check("rst_mid_nodone", 64'(gDut[0].doneCnt + gDut[1].doneCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
